// File: rtl/router_src_pkg.sv
`default_nettype none
// ============================================================================
// Package  : router_src_pkg
// Brief    : Shared types, header field positions and FSM states for the
//            router source arbiter.
// Revision : 1.0
// ============================================================================
package router_src_pkg;

    localparam int c_nreq_default = 3;

    // Header byte layout: destination address in the low bits, payload length above
    localparam int c_addr_lsb = 0;
    localparam int c_addr_msb = 1;
    localparam int c_len_lsb  = 2;
    localparam int c_len_msb  = 7;
    localparam int c_len_w    = c_len_msb - c_len_lsb + 1;

    typedef logic [7:0]         byte_t;
    typedef logic [c_len_w-1:0] len_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    function automatic len_t hdr_len(input byte_t hdr);
        return hdr[c_len_msb:c_len_lsb];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : One-hot round-robin winner; search begins at index ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import router_src_pkg::*;
#(
    parameter int NREQ  = c_nreq_default,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    logic [2*NREQ-1:0] w_req_dbl;
    logic [2*NREQ-1:0] w_win_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [NREQ-1:0]   w_win_rot;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back
    assign w_req_dbl = {req, req} >> ptr;
    assign w_req_rot = w_req_dbl[NREQ-1:0];
    assign w_win_rot = w_req_rot & (~w_req_rot + NREQ'(1));
    assign w_win_dbl = {w_win_rot, w_win_rot} << ptr;
    assign winner    = w_win_dbl[2*NREQ-1:NREQ];

endmodule
`default_nettype wire

// File: rtl/router_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : router_src_arb
// Brief    : Arbitrates byte-stream requesters onto one router source port,
//            framing header/payload and appending a parity byte per packet.
// Revision : 1.0
// ============================================================================
module router_src_arb
    import router_src_pkg::*;
#(
    parameter int NREQ = c_nreq_default
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_rdy,
    output logic [NREQ-1:0]   grant,
    output logic              pkt_vld,
    output logic [7:0]        din,
    input  logic              busy,
    input  logic              error,
    output logic              pkt_done,
    output logic              underrun,
    output logic              err_seen
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              r_state, w_state_nxt;
    logic [NREQ-1:0]     r_grant, w_grant_nxt;
    byte_t               r_din, w_din_nxt;
    logic                r_pkt_vld, w_pkt_vld_nxt;
    logic                r_pkt_done, w_pkt_done_nxt;
    logic [c_ptr_w-1:0]  r_ptr, w_ptr_nxt;
    len_t                r_len, w_len_nxt;
    len_t                r_cnt, w_cnt_nxt;
    byte_t               r_parity, w_parity_nxt;
    logic                r_abort, w_abort_nxt;
    logic                r_underrun, w_underrun_nxt;
    logic                r_err_seen;

    logic [NREQ-1:0]     w_winner;
    logic [c_ptr_w-1:0]  w_owner_idx;
    byte_t               w_owner_byte;
    logic                w_owner_vld;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (c_ptr_w)
    ) u_rr_arbiter (
        .req    (req_vld),
        .ptr    (r_ptr),
        .winner (w_winner)
    );

    // Select the current owner's lane from the one-hot grant
    always_comb begin
        w_owner_idx  = '0;
        w_owner_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_owner_idx  = c_ptr_w'(i);
                w_owner_byte = req_data[i*8 +: 8];
            end
        end
    end

    assign w_owner_vld = |(req_vld & r_grant);
    assign req_rdy     = (!busy && (r_state == ST_HEADER || r_state == ST_PAYLOAD))
                         ? r_grant : '0;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_din_nxt      = r_din;
        w_pkt_vld_nxt  = r_pkt_vld;
        w_pkt_done_nxt = 1'b0;
        w_ptr_nxt      = r_ptr;
        w_len_nxt      = r_len;
        w_cnt_nxt      = r_cnt;
        w_parity_nxt   = r_parity;
        w_abort_nxt    = r_abort;
        w_underrun_nxt = r_underrun;

        // A busy router freezes the whole packet engine, including underrun detection
        if (!busy) begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_vld) begin
                        w_grant_nxt = w_winner;
                        w_state_nxt = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_owner_vld) begin
                        w_din_nxt     = w_owner_byte;
                        w_pkt_vld_nxt = 1'b1;
                        w_len_nxt     = hdr_len(w_owner_byte);
                        w_parity_nxt  = w_owner_byte;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = (hdr_len(w_owner_byte) == '0) ? ST_PARITY : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_owner_vld) begin
                        w_din_nxt    = w_owner_byte;
                        w_parity_nxt = r_parity ^ w_owner_byte;
                        w_cnt_nxt    = r_cnt + len_t'(1);
                        if ((r_cnt + len_t'(1)) == r_len) begin
                            w_state_nxt = ST_PARITY;
                        end
                    end else begin
                        w_abort_nxt    = 1'b1;
                        w_underrun_nxt = 1'b1;
                        w_state_nxt    = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // An aborted packet carries inverted parity so the sink rejects it
                    w_din_nxt      = r_abort ? ~r_parity : r_parity;
                    w_pkt_vld_nxt  = 1'b0;
                    w_pkt_done_nxt = 1'b1;
                    w_ptr_nxt      = (w_owner_idx == c_ptr_w'(NREQ - 1))
                                     ? '0 : w_owner_idx + c_ptr_w'(1);
                    w_state_nxt    = ST_GAP;
                end
                ST_GAP: begin
                    w_grant_nxt = '0;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_din      <= 8'h00;
            r_pkt_vld  <= 1'b0;
            r_pkt_done <= 1'b0;
            r_ptr      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_parity   <= '0;
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
            r_err_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_din      <= w_din_nxt;
            r_pkt_vld  <= w_pkt_vld_nxt;
            r_pkt_done <= w_pkt_done_nxt;
            r_ptr      <= w_ptr_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_abort    <= w_abort_nxt;
            r_underrun <= w_underrun_nxt;
            r_err_seen <= r_err_seen | error;
        end
    end

    assign grant    = r_grant;
    assign din      = r_din;
    assign pkt_vld  = r_pkt_vld;
    assign pkt_done = r_pkt_done;
    assign underrun = r_underrun;
    assign err_seen = r_err_seen;

endmodule
`default_nettype wire

// File: tb/tb_router_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_src_arb
// Brief    : Directed packet scenarios plus randomized multi-requester traffic
//            scored against a packet-level round-robin model.
// Revision : 1.0
// ============================================================================
module tb_router_src_arb;

    localparam int NREQ = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ-1:0]   grant;
    logic              pkt_vld;
    logic [7:0]        din;
    logic              busy;
    logic              error;
    logic              pkt_done;
    logic              underrun;
    logic              err_seen;

    router_src_arb #(.NREQ(NREQ)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .grant    (grant),
        .pkt_vld  (pkt_vld),
        .din      (din),
        .busy     (busy),
        .error    (error),
        .pkt_done (pkt_done),
        .underrun (underrun),
        .err_seen (err_seen)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state for the randomized phase
    logic [7:0]      pq   [NREQ][$];
    int              plen [NREQ][$];
    int              total, done_cnt, model_ptr, cur_g, cur_cnt, cyc, g;
    logic [7:0]      cur_xor, b;
    bit              exp_err;
    logic [NREQ-1:0] cons, vld_s, grant_s, prev_grant;
    logic [2:0]      seq [$];
    logic [2:0]      exp28 [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] r = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) begin
                r[(p + k) % NREQ] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; req_vld = '0; req_data = '0; busy = 1'b0; error = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push_byte(input int idx, input logic [7:0] bv);
        bit ok = 1'b0;
        @(negedge clock);
        busy = 1'b0;
        req_vld[idx] = 1'b1;
        req_data[idx*8 +: 8] = bv;
        for (int k = 0; k < 20 && !ok; k++) begin
            #4;
            ok = req_rdy[idx];
            @(posedge clock); #1;
            if (!ok) @(negedge clock);
        end
        if (!ok) check_val("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_chk(input int idx, input logic [7:0] bv, input string tag);
        push_byte(idx, bv);
        check_val({tag, "_din"}, 32'(din), 32'(bv));
        check_val({tag, "_vld"}, 32'(pkt_vld), 32'd1);
    endtask

    task automatic wait_done(input logic [7:0] exp_din, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clock); #1;
            seen = pkt_done;
        end
        check_val({tag, "_done"}, 32'(pkt_done), 32'd1);
        check_val({tag, "_par"}, 32'(din), 32'(exp_din));
        check_val({tag, "_vld0"}, 32'(pkt_vld), 32'd0);
        @(posedge clock); #1;
        check_val({tag, "_pulse"}, 32'(pkt_done), 32'd0);
        check_val({tag, "_gap"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (grant != '0) return;
        end
    endtask

    initial begin
        reset = 1'b1; req_vld = '0; req_data = '0; busy = 1'b0; error = 1'b0;
        apply_reset();
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_vld", 32'(pkt_vld), 32'd0);
        check_val("rst_din", 32'(din), 32'd0);
        check_val("rst_done", 32'(pkt_done), 32'd0);
        check_val("rst_rdy", 32'(req_rdy), 32'd0);
        check_val("rst_flags", 32'({underrun, err_seen}), 32'd0);

        // Basic packet from requester 0
        push_chk(0, 8'h0C, "t27_hdr");
        push_chk(0, 8'h11, "t27_p0");
        push_chk(0, 8'h22, "t27_p1");
        push_chk(0, 8'h33, "t27_p2");
        @(negedge clock); req_vld[0] = 1'b0;
        wait_done(8'h0C, "t27");

        // Pointer moved past requester 0, so requester 1 wins a tie
        @(negedge clock);
        req_vld = 3'b011; req_data[7:0] = 8'h00; req_data[15:8] = 8'h10;
        wait_grant();
        check_val("t27_ptr", 32'(grant), 32'b010);

        // Asynchronous reset while the payload streams
        repeat (3) @(posedge clock);
        #3;
        check_val("t32_pre_vld", 32'(pkt_vld), 32'd1);
        reset = 1'b1;
        #1;
        check_val("t32_vld", 32'(pkt_vld), 32'd0);
        check_val("t32_din", 32'(din), 32'd0);
        check_val("t32_grant", 32'(grant), 32'd0);
        @(negedge clock); reset = 1'b0;
        wait_grant();
        check_val("t32_regrant", 32'(grant), 32'b001);

        // Router back-pressure after the header
        apply_reset();
        push_chk(0, 8'h0C, "t29_hdr");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            busy = 1'b1; req_data[7:0] = 8'h11;
            #1 check_val("t29_rdy", 32'(req_rdy), 32'd0);
            @(posedge clock); #1;
            check_val("t29_hold", 32'(din), 32'h0C);
            check_val("t29_vld", 32'(pkt_vld), 32'd1);
        end
        push_chk(0, 8'h11, "t29_p0");
        push_chk(0, 8'h22, "t29_p1");
        push_chk(0, 8'h33, "t29_p2");
        @(negedge clock); req_vld[0] = 1'b0;
        wait_done(8'h0C, "t29");
        check_val("t29_underrun", 32'(underrun), 32'd0);

        // Underrun: requester 1 stops mid-payload
        push_chk(1, 8'h09, "t30_hdr");
        push_chk(1, 8'hAA, "t30_p0");
        @(negedge clock); req_vld[1] = 1'b0;
        wait_done(8'h5C, "t30");
        check_val("t30_underrun", 32'(underrun), 32'd1);
        check_val("t30_err0", 32'(err_seen), 32'd0);

        // Zero-length packet, with an error pulse from the router
        push_chk(2, 8'h02, "t31_hdr");
        @(negedge clock); req_vld[2] = 1'b0; error = 1'b1;
        #1 check_val("t31_rdy", 32'(req_rdy), 32'd0);
        wait_done(8'h02, "t31");
        @(negedge clock); error = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("t31_err_sticky", 32'(err_seen), 32'd1);
        check_val("t31_underrun_sticky", 32'(underrun), 32'd1);

        // All requesters active from reset: rotation with a gap between owners
        @(negedge clock);
        reset = 1'b1; req_vld = 3'b111; req_data = '0; busy = 1'b0;
        @(negedge clock); reset = 1'b0;
        prev_grant = grant;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (grant !== prev_grant) begin
                seq.push_back(grant);
                prev_grant = grant;
            end
        end
        for (int i = 0; i < 7; i++) begin
            check_val("t28_seq", (seq.size() > i) ? 32'(seq[i]) : 32'hFFFF_FFFF, 32'(exp28[i]));
        end

        // Randomized traffic against the packet-level model
        apply_reset();
        total = 0; done_cnt = 0; model_ptr = 0; cur_g = 0; cur_cnt = 0; cur_xor = '0;
        exp_err = 1'b0; cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            int npk = $urandom_range(1, 4);
            for (int p = 0; p < npk; p++) begin
                int ln = $urandom_range(0, 5);
                logic [1:0] addr = 2'($urandom_range(0, 3));
                pq[i].push_back({6'(ln), addr});
                for (int j = 0; j < ln; j++) pq[i].push_back(8'($urandom_range(0, 255)));
                plen[i].push_back(ln + 1);
                total++;
            end
        end
        while (done_cnt < total && cyc < 4000) begin
            @(negedge clock);
            busy  = ($urandom_range(0, 9) < 3);
            error = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() > 0) begin
                    req_vld[i] = grant[i] || ($urandom_range(0, 3) != 0);
                    req_data[i*8 +: 8] = pq[i][0];
                end else begin
                    req_vld[i] = 1'b0;
                end
            end
            #4;
            cons = req_vld & req_rdy; vld_s = req_vld; grant_s = grant;
            if (error) exp_err = 1'b1;
            @(posedge clock); #1;
            cyc++;
            if (cons != '0) begin
                check_val("rnd_owner", 32'(cons), 32'(grant_s));
                g = onehot_idx(cons);
                b = pq[g].pop_front();
                cur_cnt++;
                cur_xor ^= b;
                check_val("rnd_din", 32'(din), 32'(b));
                check_val("rnd_vld", 32'(pkt_vld), 32'd1);
            end
            if (pkt_done) begin
                if (plen[cur_g].size() == 0) begin
                    check_val("rnd_spurious_done", 32'd1, 32'd0);
                end else begin
                    check_val("rnd_len", 32'(cur_cnt), 32'(plen[cur_g].pop_front()));
                end
                check_val("rnd_parity", 32'(din), 32'(cur_xor));
                check_val("rnd_vld0", 32'(pkt_vld), 32'd0);
                model_ptr = (cur_g + 1) % NREQ;
                done_cnt++;
            end
            if (grant_s == '0 && grant != '0) begin
                check_val("rnd_grant", 32'(grant), 32'(rr_pick(vld_s, model_ptr)));
                cur_g = onehot_idx(grant);
                cur_cnt = 0;
                cur_xor = '0;
            end
        end
        check_val("rnd_complete", 32'(done_cnt), 32'(total));
        check_val("rnd_underrun", 32'(underrun), 32'd0);
        check_val("rnd_err_seen", 32'(err_seen), 32'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
